// File: rtl/audio_rx_pkg.sv
// Shared types and width helpers for the audio TDM receiver.
package audio_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SHIFT = 2'd2,
    SKIP  = 2'd3
  } rx_state_e;

  // Counter width that still holds n-1 when n is 1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_WL_W   = cnt_w(16);
  localparam int DEF_SLOT_W = cnt_w(32);
  localparam int DEF_CH_W   = cnt_w(2);

endpackage

// File: rtl/audio_tdm_deserializer_if.sv
// Parallel sample output bus: valid/ready word with channel tag plus error pulses.
interface audio_tdm_deserializer_if #(
  parameter int WORD_LENGTH = 16,
  parameter int CHANNELS    = 2
) ();
  logic [WORD_LENGTH-1:0]      out_data;
  logic [$clog2(CHANNELS)-1:0] out_channel;
  logic                        out_valid;
  logic                        out_ready;
  logic                        overrun;
  logic                        frame_err;

  modport master (
    output out_data, out_channel, out_valid, overrun, frame_err,
    input  out_ready
  );

  modport slave (
    input  out_data, out_channel, out_valid, overrun, frame_err,
    output out_ready
  );
endinterface

// File: rtl/audio_edge_sync.sv
// 2-FF synchronizer for one asynchronous pin plus an edge register for rise/fall detect.
module audio_edge_sync (
  input  logic gclk,
  input  logic grst_n,
  input  logic pin_i,
  output logic synced_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sh_q;

  always_ff @(posedge gclk) begin
    if (!grst_n) sh_q <= '0;
    else         sh_q <= {sh_q[1:0], pin_i};
  end

  assign synced_o = sh_q[1];
  assign rise_o   =  sh_q[1] & ~sh_q[2];
  assign fall_o   = ~sh_q[1] &  sh_q[2];
endmodule

// File: rtl/audio_tdm_deserializer.sv
// Oversampled CODEC ADC receiver: LRCK-framed slots of SLOT_BITS ticks, one word per slot.
// Define AUDIO_I2S_ALIGN_EN for I2S (one-bit delay after LRCK fall); default is left-justified.
module audio_tdm_deserializer
  import audio_rx_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int SLOT_BITS   = 32,
  parameter int CHANNELS    = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic aud_bclk,
  input  logic aud_lrck,
  input  logic aud_adcdat,
  audio_tdm_deserializer_if.master out_if
);
  localparam int BW = cnt_w(SLOT_BITS);
  localparam int CW = cnt_w(CHANNELS);
  localparam logic [BW-1:0] WL_LAST   = BW'(WORD_LENGTH - 1);
  localparam logic [BW-1:0] SLOT_LAST = BW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(CHANNELS - 1);
`ifdef AUDIO_I2S_ALIGN_EN
  localparam rx_state_e START = ALIGN;
`else
  localparam rx_state_e START = SHIFT;
`endif

  // Pin order: [0]=bclk, [1]=lrck, [2]=adcdat
  logic [2:0] syn, rise, fall;
  audio_edge_sync u_sync [2:0] (
    .gclk    (CLOCK_50),
    .grst_n  (reset),
    .pin_i   ({aud_adcdat, aud_lrck, aud_bclk}),
    .synced_o(syn),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  logic tick, lrck_fall, din, unused_edges;
  assign tick         = rise[0];
  assign lrck_fall    = fall[1];
  assign din          = syn[2];
  assign unused_edges = ^{syn[1:0], rise[2:1], fall[2], fall[0]};

  rx_state_e              state_q, state_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [CW-1:0]          slot_q, slot_d;
  logic [WORD_LENGTH-1:0] shreg_q, shreg_d, data_q, data_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic                   valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic                   last_tick, slot_end, word_done;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      slot_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    slot_d    = slot_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    ch_d      = ch_q;
    valid_d   = valid_q;
    ovr_d     = 1'b0;
    ferr_d    = 1'b0;
    slot_end  = 1'b0;
    word_done = 1'b0;
    last_tick = tick && (slot_q == CH_LAST) && (bit_q == SLOT_LAST) &&
                (state_q == SHIFT || state_q == SKIP);

    // A coincident LRCK fall swallows the tick unless it closes the frame.
    if (tick && (!lrck_fall || last_tick)) begin
      case (state_q)
        SHIFT: begin
          shreg_d = {shreg_q[WORD_LENGTH-2:0], din};
          if (bit_q == WL_LAST) begin
            word_done = 1'b1;
            if (WORD_LENGTH == SLOT_BITS) slot_end = 1'b1;
            else begin
              state_d = SKIP;
              bit_d   = bit_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        SKIP: begin
          if (bit_q == SLOT_LAST) slot_end = 1'b1;
          else                    bit_d    = bit_q + 1'b1;
        end
`ifdef AUDIO_I2S_ALIGN_EN
        ALIGN: state_d = SHIFT;
`endif
        default: ;
      endcase
      if (slot_end) begin
        bit_d = '0;
        if (slot_q == CH_LAST) state_d = IDLE;
        else begin
          slot_d  = slot_q + 1'b1;
          state_d = SHIFT;
        end
      end
    end

    if (lrck_fall) begin
      ferr_d  = (state_q != IDLE) && !last_tick;
      state_d = START;
      bit_d   = '0;
      slot_d  = '0;
    end

    if (word_done && (!valid_q || out_if.out_ready)) begin
      data_d  = shreg_d;
      ch_d    = slot_q;
      valid_d = 1'b1;
    end else begin
      if (word_done)                    ovr_d   = 1'b1;
      if (valid_q && out_if.out_ready)  valid_d = 1'b0;
    end
  end

  assign out_if.out_data    = data_q;
  assign out_if.out_channel = ch_q;
  assign out_if.out_valid   = valid_q;
  assign out_if.overrun     = ovr_q;
  assign out_if.frame_err   = ferr_q;
endmodule

// File: tb/tb_audio_tdm_deserializer.sv
// Directed bench: stereo and 4-slot TDM receivers sharing the CODEC pins.
module tb_audio_tdm_deserializer;
  import audio_rx_pkg::*;
`ifdef AUDIO_I2S_ALIGN_EN
  localparam int AT = 1;
`else
  localparam int AT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, bclk, lrck, adcdat;
  always #5 clk = ~clk;

  audio_tdm_deserializer_if #(.WORD_LENGTH(16), .CHANNELS(2)) s_if ();
  audio_tdm_deserializer_if #(.WORD_LENGTH(24), .CHANNELS(4)) t_if ();

  audio_tdm_deserializer #(.WORD_LENGTH(16), .SLOT_BITS(32), .CHANNELS(2)) u_dut (
    .CLOCK_50(clk), .reset(rst_n), .aud_bclk(bclk), .aud_lrck(lrck),
    .aud_adcdat(adcdat), .out_if(s_if)
  );
  audio_tdm_deserializer #(.WORD_LENGTH(24), .SLOT_BITS(24), .CHANNELS(4)) u_tdm (
    .CLOCK_50(clk), .reset(rst_n), .aud_bclk(bclk), .aud_lrck(lrck),
    .aud_adcdat(adcdat), .out_if(t_if)
  );

  int checks = 0, failures = 0;
  int ovr_cnt = 0, ferr_cnt = 0;
  logic [31:0] sq_data[$], sq_ch[$], tq_data[$], tq_ch[$];
  logic [23:0] fw [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Accepted words and error pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (s_if.out_valid && s_if.out_ready) begin
      sq_data.push_back(32'(s_if.out_data));
      sq_ch.push_back(32'(s_if.out_channel));
    end
    if (t_if.out_valid && t_if.out_ready) begin
      tq_data.push_back(32'(t_if.out_data));
      tq_ch.push_back(32'(t_if.out_channel));
    end
    if (s_if.overrun)   ovr_cnt++;
    if (s_if.frame_err) ferr_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bit_period(input logic lr, input logic d);
    bclk = 1'b0; lrck = lr; adcdat = d;
    cyc(4);
    bclk = 1'b1;
    cyc(4);
  endtask

  // One idle LRCK-high tick, then nticks of frame (junk bit first in I2S).
  task automatic send_frame(input int slot, input int wl, input int nticks);
    bit_period(1'b1, 1'b0);
    for (int t = 0; t < nticks; t++) begin
      int k, s, b;
      logic [23:0] w;
      k = t - AT;
      if (k < 0) bit_period(1'b0, 1'b1);
      else begin
        s = k / slot;
        b = k % slot;
        w = fw[s];
        bit_period(s != 0, (b < wl) ? w[wl-1-b] : 1'b0);
      end
    end
    cyc(12);
  endtask

  initial begin
    int base, o0, f0;
    rst_n = 1'b0; bclk = 1'b0; lrck = 1'b1; adcdat = 1'b0;
    s_if.out_ready = 1'b1; t_if.out_ready = 1'b1;
    cyc(5);
    chk("rst_valid", 32'(s_if.out_valid), 0);
    chk("rst_data", 32'(s_if.out_data), 0);
    chk("rst_ch", 32'(s_if.out_channel), 0);
    chk("rst_ovr", 32'(s_if.overrun), 0);
    chk("rst_ferr", 32'(s_if.frame_err), 0);
    rst_n = 1'b1;
    cyc(4);

    // Basic stereo frame
    base = sq_data.size();
    fw[0] = 24'hA5C3; fw[1] = 24'h0F0F;
    send_frame(32, 16, AT + 64);
    chk("lr_cnt", sq_data.size() - base, 2);
    if (sq_data.size() >= base + 2) begin
      chk("l_data", sq_data[base], 32'hA5C3);
      chk("l_ch", sq_ch[base], 0);
      chk("r_data", sq_data[base+1], 32'h0F0F);
      chk("r_ch", sq_ch[base+1], 1);
    end

    // 4-slot TDM, word length equals slot width
    base = tq_data.size();
    fw[0] = 24'h000001; fw[1] = 24'h000002; fw[2] = 24'h000003; fw[3] = 24'h000004;
    send_frame(24, 24, AT + 96);
    chk("tdm_cnt", tq_data.size() - base, 4);
    if (tq_data.size() >= base + 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("tdm_data%0d", i), tq_data[base+i], 32'(i + 1));
        chk($sformatf("tdm_ch%0d", i), tq_ch[base+i], 32'(i));
      end

    // Backpressure: L held, R dropped with one overrun
    base = sq_data.size(); o0 = ovr_cnt;
    s_if.out_ready = 1'b0;
    fw[0] = 24'h1234; fw[1] = 24'h5678;
    send_frame(32, 16, AT + 64);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    chk("ovr_valid", 32'(s_if.out_valid), 1);
    chk("ovr_data", 32'(s_if.out_data), 32'h1234);
    chk("ovr_ch", 32'(s_if.out_channel), 0);
    chk("ovr_none_taken", sq_data.size() - base, 0);
    s_if.out_ready = 1'b1;
    cyc(4);
    chk("ovr_taken_cnt", sq_data.size() - base, 1);
    if (sq_data.size() >= base + 1) chk("ovr_taken_data", sq_data[base], 32'h1234);
    chk("ovr_valid_clr", 32'(s_if.out_valid), 0);

    // Short frame: LRCK falls 10 bits into R, then a good frame
    base = sq_data.size(); f0 = ferr_cnt;
    fw[0] = 24'hAAAA; fw[1] = 24'hFFFF;
    send_frame(32, 16, AT + 32 + 10);
    fw[0] = 24'h1111; fw[1] = 24'h2222;
    send_frame(32, 16, AT + 64);
    chk("short_ferr", ferr_cnt - f0, 1);
    chk("short_cnt", sq_data.size() - base, 3);
    if (sq_data.size() >= base + 3) begin
      chk("short_l", sq_data[base], 32'hAAAA);
      chk("short_l_ch", sq_ch[base], 0);
      chk("next_l", sq_data[base+1], 32'h1111);
      chk("next_l_ch", sq_ch[base+1], 0);
      chk("next_r", sq_data[base+2], 32'h2222);
      chk("next_r_ch", sq_ch[base+2], 1);
    end

    // Reset mid-slot aborts the frame
    fw[0] = 24'h7777; fw[1] = 24'h8888;
    bit_period(1'b1, 1'b0);
    for (int t = 0; t < AT + 8; t++) bit_period(1'b0, (t < AT) ? 1'b1 : fw[0][15-(t-AT)]);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("mrst_data", 32'(s_if.out_data), 0);
    chk("mrst_valid", 32'(s_if.out_valid), 0);
    chk("mrst_ch", 32'(s_if.out_channel), 0);
    chk("mrst_ovr", 32'(s_if.overrun), 0);
    chk("mrst_ferr", 32'(s_if.frame_err), 0);
    base = sq_data.size(); f0 = ferr_cnt;
    fw[0] = 24'hBEEF; fw[1] = 24'hCAFE;
    send_frame(32, 16, AT + 64);
    chk("post_rst_cnt", sq_data.size() - base, 2);
    chk("post_rst_ferr", ferr_cnt - f0, 0);
    if (sq_data.size() >= base + 2) begin
      chk("post_rst_l", sq_data[base], 32'hBEEF);
      chk("post_rst_r", sq_data[base+1], 32'hCAFE);
      chk("post_rst_r_ch", sq_ch[base+1], 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
